// File: rtl/control_unit_pkg.sv
// Shared types for the accumulator-machine sequencer: opcodes, FSM states,
// datapath control encodings and the bundled control word.
package opcodes;

    typedef enum logic [3:0] {
        OpNop     = 4'h0,
        OpLdi     = 4'h1,
        OpLui     = 4'h2,
        OpAdd     = 4'h3,
        OpSub     = 4'h4,
        OpAnd     = 4'h5,
        OpOr      = 4'h6,
        OpAddi    = 4'h7,
        OpSt      = 4'h8,
        OpLd      = 4'h9,
        OpIn      = 4'hA,
        OpJmp     = 4'hB,
        OpJz      = 4'hC,
        OpJnz     = 4'hD,
        OpIllegal = 4'hE,
        OpHalt    = 4'hF
    } instr_op_t;

    typedef enum logic [1:0] {
        EXEC    = 2'd0,
        WAIT_IN = 2'd1,
        HALT    = 2'd2
    } ctrl_state_t;

    typedef enum logic [1:0] {
        PcHold = 2'd0,
        PcInc  = 2'd1,
        PcJmp  = 2'd2
    } PcSel_t;

    typedef enum logic [2:0] {
        AluPassA = 3'd0,
        AluPassB = 3'd1,
        AluAdd   = 3'd2,
        AluSub   = 3'd3,
        AluAnd   = 3'd4,
        AluOr    = 3'd5
    } alu_functions_t;

    typedef struct packed {
        logic           regWe;
        logic           immSel;
        logic           wDataSel;
        logic           accStore;
        logic           op1Sel;
        alu_functions_t aluOp;
        PcSel_t         pcSel;
    } ctrl_t;

    localparam ctrl_t IdleCtrl = '{
        regWe:    1'b0,
        immSel:   1'b0,
        wDataSel: 1'b0,
        accStore: 1'b0,
        op1Sel:   1'b0,
        aluOp:    AluPassB,
        pcSel:    PcHold
    };

    // Instructions whose operand names a register and must be range-checked
    function automatic logic usesRegOperand(input instr_op_t op);
        case (op)
            OpAdd, OpSub, OpAnd, OpOr, OpSt, OpLd, OpIn: usesRegOperand = 1'b1;
            default:                                     usesRegOperand = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/control_unit_decode.sv
// Combinational instruction decode for the EXEC state: control word,
// successor state and illegal-instruction indication.
module control_decode
    import opcodes::*;
(
    input  instr_op_t   opcode,
    input  logic        regOk,
    input  logic        accZero,
    output ctrl_t       ctrl,
    output ctrl_state_t nextState,
    output logic        illegal
);

    // Anything that is not a jump, IN or HALT simply advances the PC
    always_comb begin
        ctrl       = IdleCtrl;
        ctrl.pcSel = PcInc;
        nextState  = EXEC;
        illegal    = 1'b0;

        if (usesRegOperand(opcode) && !regOk) begin
            illegal = 1'b1;
        end else begin
            case (opcode)
                OpNop: begin
                end
                OpLdi, OpLui: begin
                    ctrl.op1Sel   = 1'b1;
                    ctrl.immSel   = (opcode == OpLui);
                    ctrl.aluOp    = AluPassA;
                    ctrl.accStore = 1'b1;
                end
                OpAdd, OpSub, OpAnd, OpOr: begin
                    ctrl.op1Sel   = 1'b0;
                    ctrl.accStore = 1'b1;
                    case (opcode)
                        OpAdd:   ctrl.aluOp = AluAdd;
                        OpSub:   ctrl.aluOp = AluSub;
                        OpAnd:   ctrl.aluOp = AluAnd;
                        default: ctrl.aluOp = AluOr;
                    endcase
                end
                OpAddi: begin
                    ctrl.op1Sel   = 1'b1;
                    ctrl.immSel   = 1'b0;
                    ctrl.aluOp    = AluAdd;
                    ctrl.accStore = 1'b1;
                end
                OpSt: begin
                    ctrl.regWe    = 1'b1;
                    ctrl.wDataSel = 1'b0;
                end
                OpLd: begin
                    ctrl.op1Sel   = 1'b0;
                    ctrl.aluOp    = AluPassA;
                    ctrl.accStore = 1'b1;
                end
                OpIn: begin
                    ctrl.pcSel = PcHold;
                    nextState  = WAIT_IN;
                end
                OpJmp, OpJz, OpJnz: begin
                    if (opcode == OpJmp ||
                        (opcode == OpJz  &&  accZero) ||
                        (opcode == OpJnz && !accZero)) begin
                        ctrl.op1Sel = 1'b1;
                        ctrl.immSel = 1'b0;
                        ctrl.aluOp  = AluPassA;
                        ctrl.pcSel  = PcJmp;
                    end
                end
                OpIllegal: begin
                    illegal = 1'b1;
                end
                default: begin
                    ctrl.pcSel = PcHold;
                    nextState  = HALT;
                end
            endcase
        end
    end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle sequencer for the 8-bit accumulator datapath with Run/Step
// debug control, switch-input handshake, HALT and a retired-instruction count.
module control_unit
    import opcodes::*;
#(
    parameter int n        = 8,
    parameter int regcount = 11,
    parameter int cw       = 16
) (
    input  logic           Clock,
    input  logic           Reset,
    input  logic [n-1:0]   MemData,
    input  logic [n-1:0]   Acc,
    input  logic           Run,
    input  logic           Step,
    input  logic           SwValid,
    output logic           RegWe,
    output logic           ImmSel,
    output logic           WDataSel,
    output logic           AccStore,
    output logic           Op1Sel,
    output alu_functions_t AluOp,
    output PcSel_t         PcSel,
    output logic           SwAck,
    output logic           Halted,
    output logic           Waiting,
    output logic           IllegalOp,
    output logic [cw-1:0]  InstrCount
);

    ctrl_state_t state;
    ctrl_state_t nextState;
    ctrl_state_t decNext;
    ctrl_t       decCtrl;
    ctrl_t       ctrl;
    logic        decIllegal;
    logic        setIllegal;
    logic        stepQ;
    logic        stepEdge;
    logic        go;
    logic        retire;
    instr_op_t   opcode;
    logic [3:0]  operand;
    logic        regOk;

    assign opcode   = instr_op_t'(MemData[7:4]);
    assign operand  = MemData[3:0];
    assign regOk    = int'(operand) < regcount;
    assign stepEdge = Step & ~stepQ;
    assign go       = Run | stepEdge;

    control_decode decode (
        .opcode    (opcode),
        .regOk     (regOk),
        .accZero   (Acc == '0),
        .ctrl      (decCtrl),
        .nextState (decNext),
        .illegal   (decIllegal)
    );

    // Outputs stay idle unless an instruction is actually issued this cycle;
    // WAIT_IN ignores Run/Step and only reacts to the switch handshake
    always_comb begin
        ctrl       = IdleCtrl;
        nextState  = state;
        setIllegal = 1'b0;
        SwAck      = 1'b0;
        if (!Reset) begin
            case (state)
                EXEC: begin
                    if (go) begin
                        ctrl       = decCtrl;
                        nextState  = decNext;
                        setIllegal = decIllegal;
                    end
                end
                WAIT_IN: begin
                    if (SwValid) begin
                        ctrl.regWe    = 1'b1;
                        ctrl.wDataSel = 1'b1;
                        ctrl.pcSel    = PcInc;
                        SwAck         = 1'b1;
                        nextState     = EXEC;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign retire = (ctrl.pcSel == PcInc) || (ctrl.pcSel == PcJmp);

    // State, step edge history, sticky illegal flag and saturating counter
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state      <= EXEC;
            stepQ      <= 1'b0;
            IllegalOp  <= 1'b0;
            InstrCount <= '0;
        end else begin
            state <= nextState;
            stepQ <= Step;
            if (setIllegal)
                IllegalOp <= 1'b1;
            if (retire && (InstrCount != '1))
                InstrCount <= InstrCount + cw'(1);
        end
    end

    assign RegWe    = ctrl.regWe;
    assign ImmSel   = ctrl.immSel;
    assign WDataSel = ctrl.wDataSel;
    assign AccStore = ctrl.accStore;
    assign Op1Sel   = ctrl.op1Sel;
    assign AluOp    = ctrl.aluOp;
    assign PcSel    = ctrl.pcSel;
    assign Halted   = (state == HALT);
    assign Waiting  = (state == WAIT_IN);

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit, driving a small behavioural datapath and ROM.
module tb_control_unit;
    import opcodes::*;

    logic           Clock = 1'b0;
    logic           Reset;
    logic [7:0]     MemData;
    logic [7:0]     Acc;
    logic           Run;
    logic           Step;
    logic           SwValid;
    logic           RegWe, ImmSel, WDataSel, AccStore, Op1Sel;
    alu_functions_t AluOp;
    PcSel_t         PcSel;
    logic           SwAck, Halted, Waiting, IllegalOp;
    logic [15:0]    InstrCount;

    logic [7:0]     rom [0:31];
    logic [7:0]     regs [0:15];
    logic [4:0]     pc;
    logic [7:0]     swData;
    logic [7:0]     imm;
    logic [7:0]     opA;
    logic [7:0]     aluOut;

    int checks   = 0;
    int failures = 0;

    control_unit dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .MemData    (MemData),
        .Acc        (Acc),
        .Run        (Run),
        .Step       (Step),
        .SwValid    (SwValid),
        .RegWe      (RegWe),
        .ImmSel     (ImmSel),
        .WDataSel   (WDataSel),
        .AccStore   (AccStore),
        .Op1Sel     (Op1Sel),
        .AluOp      (AluOp),
        .PcSel      (PcSel),
        .SwAck      (SwAck),
        .Halted     (Halted),
        .Waiting    (Waiting),
        .IllegalOp  (IllegalOp),
        .InstrCount (InstrCount)
    );

    always #5 Clock = ~Clock;

    // Behavioural datapath: ROM, register file, accumulator, PC
    assign MemData = rom[pc];
    assign imm     = ImmSel ? {MemData[3:0], 4'h0} : {4'h0, MemData[3:0]};
    assign opA     = Op1Sel ? imm : regs[MemData[3:0]];

    always_comb begin
        aluOut = Acc;
        case (AluOp)
            AluPassA: aluOut = opA;
            AluPassB: aluOut = Acc;
            AluAdd:   aluOut = Acc + opA;
            AluSub:   aluOut = Acc - opA;
            AluAnd:   aluOut = Acc & opA;
            AluOr:    aluOut = Acc | opA;
            default:  aluOut = Acc;
        endcase
    end

    always @(posedge Clock) begin
        if (Reset) begin
            pc  <= '0;
            Acc <= '0;
            for (int i = 0; i < 16; i++) regs[i] <= '0;
        end else begin
            if (AccStore) Acc <= aluOut;
            if (RegWe) regs[MemData[3:0]] <= WDataSel ? swData : Acc;
            if (PcSel == PcInc) pc <= pc + 5'd1;
            else if (PcSel == PcJmp) pc <= aluOut[4:0];
        end
    end

    task automatic tick(input int cycles);
        repeat (cycles) @(negedge Clock);
    endtask

    task automatic clearRom();
        for (int i = 0; i < 32; i++) rom[i] = 8'h00;
    endtask

    task automatic doReset();
        Reset   = 1'b1;
        Run     = 1'b0;
        Step    = 1'b0;
        SwValid = 1'b0;
        tick(2);
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        clearRom();
        rom[0]  = 8'h15;
        Reset   = 1'b1;
        Run     = 1'b1;
        Step    = 1'b0;
        SwValid = 1'b0;
        swData  = 8'h00;
        tick(2);
        checks++; if (AccStore !== 1'b0) begin failures++; $display("[TB] FAIL reset_accstore got=%0d exp=0", AccStore); end
        checks++; if (Op1Sel !== 1'b0) begin failures++; $display("[TB] FAIL reset_op1sel got=%0d exp=0", Op1Sel); end
        checks++; if (PcSel !== PcHold) begin failures++; $display("[TB] FAIL reset_pcsel got=%0d exp=%0d", PcSel, PcHold); end
        checks++; if (AluOp !== AluPassB) begin failures++; $display("[TB] FAIL reset_aluop got=%0d exp=%0d", AluOp, AluPassB); end
        checks++; if (InstrCount !== 16'd0) begin failures++; $display("[TB] FAIL reset_count got=%0d exp=0", InstrCount); end
        checks++; if (IllegalOp !== 1'b0) begin failures++; $display("[TB] FAIL reset_illegal got=%0d exp=0", IllegalOp); end
        checks++; if ({Halted, Waiting} !== 2'b00) begin failures++; $display("[TB] FAIL reset_state got=%b exp=00", {Halted, Waiting}); end
        Reset = 1'b0;
        Run   = 1'b0;
        #1;
        checks++; if (PcSel !== PcHold || AccStore !== 1'b0) begin failures++; $display("[TB] FAIL idle_no_go pcsel=%0d accstore=%0d exp=0/0", PcSel, AccStore); end
    endtask

    task automatic test_program();
        clearRom();
        rom[0] = 8'h15;
        rom[1] = 8'h73;
        rom[2] = 8'h82;
        rom[3] = 8'hF0;
        doReset();
        Run = 1'b1;
        #1;
        checks++; if ({AccStore, Op1Sel, ImmSel} !== 3'b110 || AluOp !== AluPassA || PcSel !== PcInc) begin failures++; $display("[TB] FAIL ldi_decode got=%b/%0d/%0d exp=110/%0d/%0d", {AccStore, Op1Sel, ImmSel}, AluOp, PcSel, AluPassA, PcInc); end
        tick(1);
        checks++; if (Acc !== 8'd5) begin failures++; $display("[TB] FAIL ldi_acc got=%0d exp=5", Acc); end
        tick(1);
        checks++; if (Acc !== 8'd8) begin failures++; $display("[TB] FAIL addi_acc got=%0d exp=8", Acc); end
        tick(1);
        checks++; if (regs[2] !== 8'd8) begin failures++; $display("[TB] FAIL st_reg got=%0d exp=8", regs[2]); end
        checks++; if (Halted !== 1'b0 || PcSel !== PcHold) begin failures++; $display("[TB] FAIL halt_decode halted=%0d pcsel=%0d exp=0/%0d", Halted, PcSel, PcHold); end
        tick(1);
        checks++; if (Halted !== 1'b1) begin failures++; $display("[TB] FAIL halt_cycle4 got=%0d exp=1", Halted); end
        tick(3);
        checks++; if (InstrCount !== 16'd3 || pc !== 5'd3 || Halted !== 1'b1) begin failures++; $display("[TB] FAIL halt_hold count=%0d pc=%0d halted=%0d exp=3/3/1", InstrCount, pc, Halted); end
        Run = 1'b0;
    endtask

    task automatic test_step();
        clearRom();
        doReset();
        Step = 1'b1; tick(1);
        Step = 1'b0; tick(2);
        Step = 1'b1; tick(1);
        Step = 1'b0; tick(2);
        Step = 1'b1; tick(2);
        checks++; if (PcSel !== PcHold) begin failures++; $display("[TB] FAIL step_held_idle got=%0d exp=%0d", PcSel, PcHold); end
        tick(3);
        Step = 1'b0; tick(2);
        checks++; if (InstrCount !== 16'd3 || pc !== 5'd3) begin failures++; $display("[TB] FAIL step_retires count=%0d pc=%0d exp=3/3", InstrCount, pc); end
        Run  = 1'b1;
        Step = 1'b1; tick(1);
        Step = 1'b0; tick(1);
        Step = 1'b1; tick(1);
        Step = 1'b0; tick(1);
        Run  = 1'b0;
        checks++; if (InstrCount !== 16'd7 || pc !== 5'd7) begin failures++; $display("[TB] FAIL step_absorbed count=%0d pc=%0d exp=7/7", InstrCount, pc); end
    endtask

    task automatic test_in();
        int waitCycles;
        int ackSeen;
        clearRom();
        rom[0] = 8'hA4;
        doReset();
        Run = 1'b1;
        #1;
        checks++; if (PcSel !== PcHold || RegWe !== 1'b0 || Waiting !== 1'b0) begin failures++; $display("[TB] FAIL in_decode pcsel=%0d regwe=%0d waiting=%0d exp=0/0/0", PcSel, RegWe, Waiting); end
        tick(1);
        Run        = 1'b0;
        waitCycles = 0;
        ackSeen    = 0;
        for (int i = 0; i < 6; i++) begin
            if (Waiting === 1'b1) waitCycles++;
            if (SwAck !== 1'b0 || RegWe !== 1'b0) ackSeen++;
            tick(1);
        end
        checks++; if (waitCycles !== 6 || ackSeen !== 0) begin failures++; $display("[TB] FAIL in_wait waiting=%0d early_ack=%0d exp=6/0", waitCycles, ackSeen); end
        SwValid = 1'b1;
        swData  = 8'hA5;
        #1;
        checks++; if ({SwAck, RegWe, WDataSel} !== 3'b111 || PcSel !== PcInc) begin failures++; $display("[TB] FAIL in_ack got=%b/%0d exp=111/%0d", {SwAck, RegWe, WDataSel}, PcSel, PcInc); end
        tick(1);
        SwValid = 1'b0;
        #1;
        checks++; if (Waiting !== 1'b0 || SwAck !== 1'b0) begin failures++; $display("[TB] FAIL in_exit waiting=%0d swack=%0d exp=0/0", Waiting, SwAck); end
        checks++; if (regs[4] !== 8'hA5 || pc !== 5'd1 || InstrCount !== 16'd1) begin failures++; $display("[TB] FAIL in_commit r4=%0h pc=%0d count=%0d exp=a5/1/1", regs[4], pc, InstrCount); end
    endtask

    task automatic test_jumps();
        clearRom();
        rom[0]  = 8'h10;
        rom[1]  = 8'hC9;
        rom[9]  = 8'h11;
        rom[10] = 8'hD0;
        doReset();
        Run = 1'b1;
        tick(1);
        checks++; if (PcSel !== PcJmp || AluOp !== AluPassA || Op1Sel !== 1'b1) begin failures++; $display("[TB] FAIL jz_taken_decode pcsel=%0d aluop=%0d op1sel=%0d exp=%0d/%0d/1", PcSel, AluOp, Op1Sel, PcJmp, AluPassA); end
        tick(1);
        checks++; if (pc !== 5'd9) begin failures++; $display("[TB] FAIL jz_taken_pc got=%0d exp=9", pc); end
        tick(2);
        Run = 1'b0;
        checks++; if (pc !== 5'd0 || InstrCount !== 16'd4) begin failures++; $display("[TB] FAIL jnz_taken pc=%0d count=%0d exp=0/4", pc, InstrCount); end
        clearRom();
        rom[0] = 8'h11;
        rom[1] = 8'hC9;
        rom[2] = 8'hF0;
        doReset();
        Run = 1'b1;
        tick(1);
        checks++; if (PcSel !== PcInc) begin failures++; $display("[TB] FAIL jz_not_taken_decode got=%0d exp=%0d", PcSel, PcInc); end
        tick(1);
        Run = 1'b0;
        checks++; if (pc !== 5'd2) begin failures++; $display("[TB] FAIL jz_not_taken_pc got=%0d exp=2", pc); end
    endtask

    task automatic test_illegal();
        clearRom();
        rom[0] = 8'h17;
        rom[1] = 8'hE0;
        rom[2] = 8'h3C;
        rom[3] = 8'hAC;
        rom[4] = 8'hF0;
        doReset();
        Run = 1'b1;
        tick(1);
        checks++; if (IllegalOp !== 1'b0 || Acc !== 8'd7) begin failures++; $display("[TB] FAIL illegal_pre flag=%0d acc=%0d exp=0/7", IllegalOp, Acc); end
        checks++; if (PcSel !== PcInc || AccStore !== 1'b0) begin failures++; $display("[TB] FAIL op_e_decode pcsel=%0d accstore=%0d exp=%0d/0", PcSel, AccStore, PcInc); end
        tick(1);
        checks++; if (IllegalOp !== 1'b1) begin failures++; $display("[TB] FAIL op_e_flag got=%0d exp=1", IllegalOp); end
        checks++; if (AccStore !== 1'b0 || PcSel !== PcInc) begin failures++; $display("[TB] FAIL add12_decode accstore=%0d pcsel=%0d exp=0/%0d", AccStore, PcSel, PcInc); end
        tick(1);
        checks++; if (Acc !== 8'd7 || pc !== 5'd3 || InstrCount !== 16'd3) begin failures++; $display("[TB] FAIL add12_nop acc=%0d pc=%0d count=%0d exp=7/3/3", Acc, pc, InstrCount); end
        tick(1);
        checks++; if (Waiting !== 1'b0 || pc !== 5'd4) begin failures++; $display("[TB] FAIL in12_nop waiting=%0d pc=%0d exp=0/4", Waiting, pc); end
        tick(2);
        Run = 1'b0;
        checks++; if (IllegalOp !== 1'b1 || Halted !== 1'b1) begin failures++; $display("[TB] FAIL illegal_sticky flag=%0d halted=%0d exp=1/1", IllegalOp, Halted); end
        doReset();
        checks++; if (IllegalOp !== 1'b0) begin failures++; $display("[TB] FAIL illegal_clear got=%0d exp=0", IllegalOp); end
    endtask

    task automatic test_reset_in_wait();
        clearRom();
        rom[0] = 8'hA3;
        doReset();
        Run = 1'b1;
        tick(1);
        Run = 1'b0;
        checks++; if (Waiting !== 1'b1) begin failures++; $display("[TB] FAIL rst_wait_enter got=%0d exp=1", Waiting); end
        Reset   = 1'b1;
        SwValid = 1'b1;
        swData  = 8'h3C;
        #1;
        checks++; if (SwAck !== 1'b0 || RegWe !== 1'b0 || PcSel !== PcHold) begin failures++; $display("[TB] FAIL rst_wait_idle swack=%0d regwe=%0d pcsel=%0d exp=0/0/0", SwAck, RegWe, PcSel); end
        tick(1);
        Reset   = 1'b0;
        SwValid = 1'b0;
        #1;
        checks++; if (Waiting !== 1'b0 || InstrCount !== 16'd0 || regs[3] !== 8'd0) begin failures++; $display("[TB] FAIL rst_wait_exit waiting=%0d count=%0d r3=%0d exp=0/0/0", Waiting, InstrCount, regs[3]); end
    endtask

    initial begin
        test_reset();
        test_program();
        test_step();
        test_in();
        test_jumps();
        test_illegal();
        test_reset_in_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
